vga_ctrl: RTL and testbench

- Timing generator and pixel sink for the 640x480@60 Hz VGA output path, clocked by the 25.175 MHz (nominally 25 MHz) vga_clk.
- Runs free-running horizontal and vertical counters and issues pixel-coordinate requests (pix_x/pix_y) one cycle ahead of display, so the registered pixel generator can answer.
- Gates the returned pix_data onto the rgb output during the active window and produces hsync/vsync plus frame bookkeeping.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_sync_cnt.sv | 53 +++++
 rtl/vga_ctrl.sv | 109 ++++++++++
 tb/tb_vga_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and colour constants for the VGA path.
// Also used by the pixel generators so their coordinate ranges agree with the controller.
package vga_timing_pkg;

    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BACK   = 10'd40;
    localparam logic [9:0] H_LEFT   = 10'd8;
    localparam logic [9:0] H_VALID  = 10'd640;
    localparam logic [9:0] H_RIGHT  = 10'd8;
    localparam logic [9:0] H_FRONT  = 10'd8;

    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BACK   = 10'd25;
    localparam logic [9:0] V_TOP    = 10'd8;
    localparam logic [9:0] V_VALID  = 10'd480;
    localparam logic [9:0] V_BOTTOM = 10'd8;
    localparam logic [9:0] V_FRONT  = 10'd2;

    localparam logic [9:0] H_TOTAL  = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam logic [9:0] V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam logic [9:0] HS       = H_SYNC + H_BACK + H_LEFT;
    localparam logic [9:0] HE       = HS + H_VALID;
    localparam logic [9:0] VS       = V_SYNC + V_BACK + V_TOP;
    localparam logic [9:0] VE       = VS + V_VALID;

    localparam logic [15:0] C_BLACK = 16'h0000;
    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [9:0]  COORD_NONE = 10'h3FF;

    function automatic logic in_range(input logic [9:0] val, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// Cascaded horizontal/vertical wrap counters with line-end and frame-end strobes.
module vga_sync_cnt
    import vga_timing_pkg::*;
#(
    parameter logic [9:0] P_H_TOTAL = H_TOTAL,
    parameter logic [9:0] P_V_TOTAL = V_TOTAL
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] cnt_h_o,
    output logic [9:0] cnt_v_o,
    output logic       line_end_o,
    output logic       frame_end_o
);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       line_end_s;
    logic       last_line_s;

    always_comb begin
        line_end_s  = (cnt_h_q == (P_H_TOTAL - 10'd1));
        last_line_s = (cnt_v_q == (P_V_TOTAL - 10'd1));
        cnt_h_d     = cnt_h_q;
        cnt_v_d     = cnt_v_q;
        if (line_end_s) begin
            cnt_h_d = 10'd0;
            if (last_line_s) begin
                cnt_v_d = 10'd0;
            end else begin
                cnt_v_d = cnt_v_q + 10'd1;
            end
        end else begin
            cnt_h_d = cnt_h_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    assign cnt_h_o     = cnt_h_q;
    assign cnt_v_o     = cnt_v_q;
    assign line_end_o  = line_end_s;
    assign frame_end_o = line_end_s & last_line_s;

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel sink: issues pixel requests one cycle ahead of
// display, gates returned pixels onto rgb, and keeps frame bookkeeping.
module vga_ctrl
    import vga_timing_pkg::*;
#(
    parameter logic [9:0] P_H_SYNC   = H_SYNC,
    parameter logic [9:0] P_H_BACK   = H_BACK,
    parameter logic [9:0] P_H_LEFT   = H_LEFT,
    parameter logic [9:0] P_H_VALID  = H_VALID,
    parameter logic [9:0] P_H_RIGHT  = H_RIGHT,
    parameter logic [9:0] P_H_FRONT  = H_FRONT,
    parameter logic [9:0] P_V_SYNC   = V_SYNC,
    parameter logic [9:0] P_V_BACK   = V_BACK,
    parameter logic [9:0] P_V_TOP    = V_TOP,
    parameter logic [9:0] P_V_VALID  = V_VALID,
    parameter logic [9:0] P_V_BOTTOM = V_BOTTOM,
    parameter logic [9:0] P_V_FRONT  = V_FRONT
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_data_req,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam logic [9:0] L_H_TOTAL = P_H_SYNC + P_H_BACK + P_H_LEFT + P_H_VALID
                                     + P_H_RIGHT + P_H_FRONT;
    localparam logic [9:0] L_V_TOTAL = P_V_SYNC + P_V_BACK + P_V_TOP + P_V_VALID
                                     + P_V_BOTTOM + P_V_FRONT;
    localparam logic [9:0] L_HS      = P_H_SYNC + P_H_BACK + P_H_LEFT;
    localparam logic [9:0] L_HE      = L_HS + P_H_VALID;
    localparam logic [9:0] L_VS      = P_V_SYNC + P_V_BACK + P_V_TOP;
    localparam logic [9:0] L_VE      = L_VS + P_V_VALID;
    // Requests run one column ahead so a registered source lines up with rgb_valid.
    localparam logic [9:0] L_REQ_HS  = L_HS - 10'd1;
    localparam logic [9:0] L_REQ_HE  = L_HE - 10'd1;

    logic [9:0] cnt_h_s;
    logic [9:0] cnt_v_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic       v_act_s;
    logic       h_act_s;
    logic       h_req_s;
    logic       req_s;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    vga_sync_cnt #(
        .P_H_TOTAL (L_H_TOTAL),
        .P_V_TOTAL (L_V_TOTAL)
    ) u_sync_cnt (
        .clk_i       (vga_clk),
        .rst_i       (sys_rst),
        .cnt_h_o     (cnt_h_s),
        .cnt_v_o     (cnt_v_s),
        .line_end_o  (line_end_s),
        .frame_end_o (frame_end_s)
    );

    always_comb begin
        v_act_s = in_range(cnt_v_s, L_VS, L_VE);
        h_act_s = in_range(cnt_h_s, L_HS, L_HE);
        h_req_s = in_range(cnt_h_s, L_REQ_HS, L_REQ_HE);
        req_s   = h_req_s & v_act_s;
        if (req_s) begin
            pix_x = cnt_h_s - L_REQ_HS;
            pix_y = cnt_v_s - L_VS;
        end else begin
            pix_x = COORD_NONE;
            pix_y = COORD_NONE;
        end
    end

    always_comb begin
        frame_start_d = frame_end_s;
        if (frame_end_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync        = (cnt_h_s < P_H_SYNC);
    assign vsync        = (cnt_v_s < P_V_SYNC);
    assign pix_data_req = req_s;
    assign rgb_valid    = h_act_s & v_act_s;
    assign rgb          = (h_act_s & v_act_s) ? pix_data : C_BLACK;
    assign frame_start  = frame_start_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench: full-size controller for line/alignment/blanking, plus a reduced
// timing instance so frame-level behaviour fits in a short run.
module tb_vga_ctrl;

    logic        clk;
    logic        sys_rst;
    logic        mode_white;
    logic [15:0] pix_q;
    logic [9:0]  pix_x, pix_y;
    logic        req, hsync, vsync, rgb_valid, frame_start;
    logic [15:0] rgb;
    logic [7:0]  frame_cnt;

    logic        s_rst;
    logic [9:0]  s_pix_x, s_pix_y;
    logic        s_req, s_hsync, s_vsync, s_rgb_valid, s_frame_start;
    logic [15:0] s_rgb;
    logic [7:0]  s_frame_cnt;

    int ncmp = 0;
    int nerr = 0;
    int n    = 0;
    int ns   = 0;

    vga_ctrl dut (
        .vga_clk(clk), .sys_rst(sys_rst), .pix_data(pix_q),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data_req(req),
        .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid), .rgb(rgb),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Reduced timing: H_TOTAL=10 (active 4..7, req 3..6), V_TOTAL=8 (active 3..5), frame=80
    vga_ctrl #(
        .P_H_SYNC(10'd2), .P_H_BACK(10'd1), .P_H_LEFT(10'd1), .P_H_VALID(10'd4),
        .P_H_RIGHT(10'd1), .P_H_FRONT(10'd1),
        .P_V_SYNC(10'd1), .P_V_BACK(10'd1), .P_V_TOP(10'd1), .P_V_VALID(10'd3),
        .P_V_BOTTOM(10'd1), .P_V_FRONT(10'd1)
    ) dut_s (
        .vga_clk(clk), .sys_rst(s_rst), .pix_data(16'hFFFF),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_data_req(s_req),
        .hsync(s_hsync), .vsync(s_vsync), .rgb_valid(s_rgb_valid), .rgb(s_rgb),
        .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered pixel source answering the previous cycle's request
    always @(posedge clk) pix_q <= mode_white ? 16'hFFFF : {6'b0, pix_x};

    task automatic step();
        @(posedge clk);
        #1;
        n  = n + 1;
        ns = ns + 1;
    endtask

    task automatic goto(input int target);
        while (n < target) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            ncmp++; if (hsync !== 1'b1) begin nerr++; $display("FAIL rst_hsync got %b exp 1", hsync); end
            ncmp++; if (vsync !== 1'b1) begin nerr++; $display("FAIL rst_vsync got %b exp 1", vsync); end
            ncmp++; if (rgb !== 16'h0000) begin nerr++; $display("FAIL rst_rgb got %h exp 0000", rgb); end
            ncmp++; if (pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
                nerr++; $display("FAIL rst_pix got %h/%h exp 3ff/3ff", pix_x, pix_y); end
            ncmp++; if (req !== 1'b0 || rgb_valid !== 1'b0) begin
                nerr++; $display("FAIL rst_req_valid got %b/%b exp 0/0", req, rgb_valid); end
            ncmp++; if (frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
                nerr++; $display("FAIL rst_frame got %b/%0d exp 0/0", frame_start, frame_cnt); end
            ncmp++; if (s_frame_cnt !== 8'd0) begin
                nerr++; $display("FAIL rst_small_frame_cnt got %0d exp 0", s_frame_cnt); end
        end
        sys_rst = 1'b0;
        n = 0;
    endtask

    task automatic test_line_timing();
        int hs_hi = 0, hs_lo = 0, vs_hi = 0, req_cnt = 0;
        while (n < 1700) begin
            if (n < 800) begin
                if (hsync === 1'b1) hs_hi++;
                if (hsync === 1'b0) hs_lo++;
            end
            if (vsync === 1'b1) vs_hi++;
            if (req === 1'b1) req_cnt++;
            if (n == 799) begin
                ncmp++; if (hsync !== 1'b0) begin nerr++; $display("FAIL line_end_hsync got %b exp 0", hsync); end
            end
            if (n == 800) begin
                ncmp++; if (hsync !== 1'b1) begin nerr++; $display("FAIL line_period_hsync got %b exp 1", hsync); end
            end
            step();
        end
        ncmp++; if (hs_hi != 96) begin nerr++; $display("FAIL hsync_high got %0d exp 96", hs_hi); end
        ncmp++; if (hs_lo != 704) begin nerr++; $display("FAIL hsync_low got %0d exp 704", hs_lo); end
        ncmp++; if (vs_hi != 1600) begin nerr++; $display("FAIL vsync_high got %0d exp 1600", vs_hi); end
        ncmp++; if (req_cnt != 0) begin nerr++; $display("FAIL blank_line_req got %0d exp 0", req_cnt); end
    endtask

    task automatic test_alignment();
        int req_cnt = 0;
        int h;
        goto(34 * 800 + 143);
        ncmp++; if (req !== 1'b0) begin nerr++; $display("FAIL line34_req got %b exp 0", req); end
        goto(35 * 800);
        while (n < 36 * 800) begin
            h = n - 35 * 800;
            if (req === 1'b1) req_cnt++;
            if (h == 142) begin
                ncmp++; if (req !== 1'b0 || pix_x !== 10'h3FF) begin
                    nerr++; $display("FAIL pre_req got %b/%h exp 0/3ff", req, pix_x); end
            end
            if (h == 143) begin
                ncmp++; if (req !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0 || rgb_valid !== 1'b0) begin
                    nerr++; $display("FAIL first_req got req=%b x=%h y=%h v=%b exp 1/000/000/0",
                                     req, pix_x, pix_y, rgb_valid); end
            end
            if (h == 144) begin
                ncmp++; if (rgb_valid !== 1'b1 || rgb !== 16'd0 || pix_x !== 10'd1) begin
                    nerr++; $display("FAIL first_pix got v=%b rgb=%h x=%h exp 1/0000/001",
                                     rgb_valid, rgb, pix_x); end
            end
            if (h == 782) begin
                ncmp++; if (pix_x !== 10'd639 || pix_y !== 10'd0) begin
                    nerr++; $display("FAIL last_req got %h/%h exp 27f/000", pix_x, pix_y); end
            end
            if (h == 783) begin
                ncmp++; if (rgb !== 16'd639 || rgb_valid !== 1'b1 || req !== 1'b0 || pix_x !== 10'h3FF) begin
                    nerr++; $display("FAIL last_pix got rgb=%h v=%b req=%b x=%h exp 027f/1/0/3ff",
                                     rgb, rgb_valid, req, pix_x); end
            end
            if (h == 784) begin
                ncmp++; if (rgb_valid !== 1'b0 || rgb !== 16'd0) begin
                    nerr++; $display("FAIL after_pix got v=%b rgb=%h exp 0/0000", rgb_valid, rgb); end
            end
            step();
        end
        ncmp++; if (req_cnt != 640) begin nerr++; $display("FAIL req_per_line got %0d exp 640", req_cnt); end
    endtask

    task automatic test_blanking();
        int white = 0;
        int h;
        logic exp_v;
        mode_white = 1'b1;
        while (n < 37 * 800) begin
            h = n - 36 * 800;
            exp_v = (h >= 144) && (h < 784);
            if (rgb === 16'hFFFF) white++;
            ncmp++; if (rgb_valid !== exp_v || rgb !== (exp_v ? 16'hFFFF : 16'h0000)) begin
                nerr++; $display("FAIL blank h=%0d got v=%b rgb=%h exp v=%b", h, rgb_valid, rgb, exp_v); end
            if (h == 143) begin
                ncmp++; if (pix_y !== 10'd1) begin nerr++; $display("FAIL row1_y got %h exp 001", pix_y); end
            end
            step();
        end
        ncmp++; if (white != 640) begin nerr++; $display("FAIL white_per_line got %0d exp 640", white); end
        mode_white = 1'b0;
    endtask

    task automatic test_mid_reset_main();
        goto(37 * 800 + 400);
        ncmp++; if (pix_x !== 10'd257 || pix_y !== 10'd2) begin
            nerr++; $display("FAIL pre_mid_reset got %h/%h exp 101/002", pix_x, pix_y); end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        n = 0;
        ncmp++; if (hsync !== 1'b1 || vsync !== 1'b1 || pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
            nerr++; $display("FAIL mid_reset got hs=%b vs=%b x=%h y=%h exp 1/1/3ff/3ff",
                             hsync, vsync, pix_x, pix_y); end
        ncmp++; if (frame_cnt !== 8'd0 || frame_start !== 1'b0 || rgb !== 16'd0) begin
            nerr++; $display("FAIL mid_reset_frame got %0d/%b/%h exp 0/0/0000",
                             frame_cnt, frame_start, rgb); end
        step();
        step();
        ncmp++; if (hsync !== 1'b1 || vsync !== 1'b1 || req !== 1'b0) begin
            nerr++; $display("FAIL post_reset got hs=%b vs=%b req=%b exp 1/1/0", hsync, vsync, req); end
    endtask

    task automatic test_frame();
        int h, v, vs_hi, white, fs_cnt;
        logic exp_fs, exp_req, exp_v;
        logic [7:0] exp_cnt;
        logic [9:0] exp_x, exp_y;
        vs_hi = 0; white = 0; fs_cnt = 0;
        s_rst = 1'b0;
        ns = 0;
        while (ns < 257 * 80 + 45) begin
            h = ns % 10;
            v = (ns / 10) % 8;
            exp_fs  = (ns >= 80) && (ns % 80 == 0);
            exp_cnt = 8'((ns / 80) % 256);
            exp_req = (h >= 3) && (h < 7) && (v >= 3) && (v < 6);
            exp_v   = (h >= 4) && (h < 8) && (v >= 3) && (v < 6);
            exp_x   = exp_req ? 10'(h - 3) : 10'h3FF;
            exp_y   = exp_req ? 10'(v - 3) : 10'h3FF;
            if (ns < 80) begin
                if (s_vsync === 1'b1) vs_hi++;
                if (s_rgb === 16'hFFFF) white++;
            end
            if (s_frame_start === 1'b1) fs_cnt++;
            ncmp++; if (s_frame_start !== exp_fs || s_frame_cnt !== exp_cnt) begin
                nerr++; $display("FAIL frame ns=%0d got fs=%b cnt=%0d exp fs=%b cnt=%0d",
                                 ns, s_frame_start, s_frame_cnt, exp_fs, exp_cnt); end
            ncmp++; if (s_req !== exp_req || s_pix_x !== exp_x || s_pix_y !== exp_y
                        || s_rgb_valid !== exp_v || s_rgb !== (exp_v ? 16'hFFFF : 16'h0000)) begin
                nerr++; $display("FAIL small_pix ns=%0d got req=%b x=%h y=%h v=%b exp %b/%h/%h/%b",
                                 ns, s_req, s_pix_x, s_pix_y, s_rgb_valid, exp_req, exp_x, exp_y, exp_v); end
            ncmp++; if (s_hsync !== (h < 2) || s_vsync !== (v < 1)) begin
                nerr++; $display("FAIL small_sync ns=%0d got %b/%b", ns, s_hsync, s_vsync); end
            step();
        end
        ncmp++; if (vs_hi != 10) begin nerr++; $display("FAIL small_vsync_high got %0d exp 10", vs_hi); end
        ncmp++; if (white != 12) begin nerr++; $display("FAIL small_white got %0d exp 12", white); end
        ncmp++; if (fs_cnt != 257) begin nerr++; $display("FAIL frame_pulses got %0d exp 257", fs_cnt); end
        ncmp++; if (s_frame_cnt !== 8'd1 || s_req !== 1'b1) begin
            nerr++; $display("FAIL pre_small_reset got cnt=%0d req=%b exp 1/1", s_frame_cnt, s_req); end
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        ncmp++; if (s_frame_cnt !== 8'd0 || s_frame_start !== 1'b0 || s_pix_x !== 10'h3FF
                    || s_hsync !== 1'b1 || s_vsync !== 1'b1) begin
            nerr++; $display("FAIL small_mid_reset got cnt=%0d fs=%b x=%h hs=%b vs=%b exp 0/0/3ff/1/1",
                             s_frame_cnt, s_frame_start, s_pix_x, s_hsync, s_vsync); end
    endtask

    initial begin
        sys_rst    = 1'b1;
        s_rst      = 1'b1;
        mode_white = 1'b0;
        test_reset();
        test_line_timing();
        test_alignment();
        test_blanking();
        test_mid_reset_main();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
